// File: rtl/fm_ch_attr_db.sv
// Double-buffered FM channel attribute store.
// The CPU edits a shadow bank; dirty channels are copied into the active bank
// in one sweep that starts on the first frame_start after a commit request, so a
// multi-channel update reaches the operator sequencer atomically.
//
// state | meaning
// CLEAR | zero both banks, one channel per cycle (after reset)
// IDLE  | bus writes accepted, no commit outstanding
// WAIT  | commit requested, waiting for frame_start
// COPY  | dirty shadow -> active, one channel per cycle
module fm_ch_attr_db #(
  parameter int NUM_CH  = 32,
  parameter int CH_BITS = 5,
  parameter int DATA_W  = 23
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CH_BITS-1:0] addr,
  input  logic [31:0]        wrdata,
  input  logic               wren,
  output logic [31:0]        rddata,
  input  logic               commit_req,
  input  logic               frame_start,
  output logic               busy,
  output logic               pending,
  output logic               commit_done,
  output logic               wr_drop,
  input  logic [CH_BITS-1:0] ch_sel,
  output logic [DATA_W-1:0]  ch_attr
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_COPY  = 2'd3
  } state_t;

  localparam logic [CH_BITS-1:0] IDX_LAST = CH_BITS'(NUM_CH - 1);

  state_t              state;
  logic [CH_BITS-1:0]  idx;
  logic [NUM_CH-1:0]   dirty;
  logic [DATA_W-1:0]   shadow [NUM_CH];
  logic [DATA_W-1:0]   active [NUM_CH];

  logic wr_ok;
  logic copy_en;
  logic idx_last;
  logic unused_wrdata_hi;

  assign busy     = (state == S_CLEAR) || (state == S_COPY);
  assign wr_ok    = wren && !busy;
  assign copy_en  = (state == S_COPY) && dirty[idx];
  assign idx_last = (idx == IDX_LAST);
  assign rddata   = {{(32-DATA_W){1'b0}}, shadow[addr]};
  assign unused_wrdata_hi = ^wrdata[31:DATA_W];

  // Sequencer FSM: sweep index, commit bookkeeping and sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_CLEAR;
      idx         <= '0;
      pending     <= 1'b0;
      commit_done <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      if (wren && busy) wr_drop <= 1'b1;
      case (state)
        S_CLEAR: begin
          if (commit_req) pending <= 1'b1;
          idx <= idx + CH_BITS'(1);
          // a commit raised during the clear sweep is honoured, not lost
          if (idx_last) state <= (pending || commit_req) ? S_WAIT : S_IDLE;
        end
        S_IDLE: begin
          if (commit_req) begin
            pending <= 1'b1;
            wr_drop <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_start) begin
            idx     <= '0;
            pending <= 1'b0;
            state   <= S_COPY;
          end
        end
        S_COPY: begin
          if (commit_req) pending <= 1'b1;
          idx <= idx + CH_BITS'(1);
          if (idx_last) begin
            commit_done <= 1'b1;
            state       <= (pending || commit_req) ? S_WAIT : S_IDLE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Dirty tracking: set by accepted bus writes, cleared as COPY transfers a channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= '0;
    end else begin
      if (wr_ok)   dirty[addr] <= 1'b1;
      if (copy_en) dirty[idx]  <= 1'b0;
    end
  end

  // Bank storage: no reset so the banks map onto distributed RAM; CLEAR zeroes them.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      shadow[idx] <= '0;
      active[idx] <= '0;
    end else begin
      if (wr_ok)   shadow[addr] <= wrdata[DATA_W-1:0];
      if (copy_en) active[idx]  <= shadow[idx];
    end
  end

  // Synth read port: one-cycle registered read of the active bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ch_attr <= '0;
    else          ch_attr <= active[ch_sel];
  end

endmodule

// File: tb/tb_fm_ch_attr_db.sv
// Scoreboard bench for fm_ch_attr_db: stimulus pushes expected values into
// per-output queues, a monitor pops and compares when the output is presented.
module tb_fm_ch_attr_db;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  addr;
  logic [31:0] wrdata;
  logic        wren;
  logic [31:0] rddata;
  logic        commit_req;
  logic        frame_start;
  logic        busy;
  logic        pending;
  logic        commit_done;
  logic        wr_drop;
  logic [4:0]  ch_sel;
  logic [22:0] ch_attr;

  fm_ch_attr_db #(.NUM_CH(32), .CH_BITS(5), .DATA_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wrdata(wrdata), .wren(wren),
    .rddata(rddata), .commit_req(commit_req), .frame_start(frame_start),
    .busy(busy), .pending(pending), .commit_done(commit_done), .wr_drop(wr_drop),
    .ch_sel(ch_sel), .ch_attr(ch_attr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t q_rd[$];
  exp_t q_stat[$];
  exp_t q_attr[$];
  exp_t q_done[$];
  exp_t q_busy[$];

  int checks = 0;
  int failures = 0;

  logic rd_req = 1'b0;
  logic stat_req = 1'b0;
  logic attr_req = 1'b0;
  logic attr_pipe = 1'b0;
  int   run = 0;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void underflow(string what);
    checks++;
    failures++;
    $display("FAIL %s: output presented with no expectation queued", what);
  endfunction

  // ch_attr is valid one cycle after the read request
  always @(posedge clk) attr_pipe <= attr_req;

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rd_req) begin
      if (q_rd.size() == 0) underflow("rddata");
      else begin e = q_rd.pop_front(); cmp(e.nm, rddata, e.v); end
    end
    if (stat_req) begin
      if (q_stat.size() == 0) underflow("status");
      else begin
        e = q_stat.pop_front();
        cmp(e.nm, {28'd0, busy, pending, wr_drop, commit_done}, e.v);
      end
    end
    if (attr_pipe) begin
      if (q_attr.size() == 0) underflow("ch_attr");
      else begin e = q_attr.pop_front(); cmp(e.nm, {9'd0, ch_attr}, e.v); end
    end
    if (reset_n && commit_done) begin
      if (q_done.size() == 0) underflow("commit_done");
      else begin e = q_done.pop_front(); cmp(e.nm, {30'd0, busy, pending}, e.v); end
    end
    if (!reset_n) run = 0;
    else if (busy) run++;
    else if (run > 0) begin
      if (q_busy.size() == 0) underflow("busy_run");
      else begin e = q_busy.pop_front(); cmp(e.nm, run, e.v); end
      run = 0;
    end
  end

  function automatic void push(output exp_t e, input string nm, input logic [31:0] v);
    e.nm = nm;
    e.v  = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wrdata = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic chk_rd(input logic [4:0] a, input logic [31:0] v, input string nm);
    exp_t e;
    push(e, nm, v);
    q_rd.push_back(e);
    addr = a; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic chk_attr(input logic [4:0] ch, input logic [31:0] v, input string nm);
    exp_t e;
    push(e, nm, v);
    q_attr.push_back(e);
    ch_sel = ch; attr_req = 1'b1;
    tick();
    attr_req = 1'b0;
  endtask

  // expected {busy, pending, wr_drop, commit_done}
  task automatic chk_stat(input logic b, input logic p, input logic w, input string nm);
    exp_t e;
    push(e, nm, {28'd0, b, p, w, 1'b0});
    q_stat.push_back(e);
    stat_req = 1'b1;
    tick();
    stat_req = 1'b0;
  endtask

  task automatic expect_busy(input string nm);
    exp_t e;
    push(e, nm, 32);
    q_busy.push_back(e);
  endtask

  task automatic expect_done(input logic p, input string nm);
    exp_t e;
    push(e, nm, {30'd0, 1'b0, p});
    q_done.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) cmp({nm, "_timeout"}, 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; addr = '0; wrdata = '0; wren = 1'b0;
    commit_req = 1'b0; frame_start = 1'b0; ch_sel = '0;

    // 1: reset values and the clear sweep
    cyc(3);
    chk_stat(1'b1, 1'b0, 1'b0, "rst_status");
    chk_attr(5'd0, 0, "rst_ch_attr");
    expect_busy("clear_len");
    reset_n = 1'b1;
    wait_idle("clear");
    chk_stat(1'b0, 1'b0, 1'b0, "post_clear_status");
    for (int c = 0; c < 32; c++) begin
      chk_rd(5'(c), 0, "clear_rddata");
      chk_attr(5'(c), 0, "clear_ch_attr");
    end

    // 2: basic commit, upper bus bits ignored
    wr(5'd3, 32'h0001_2345);
    wr(5'd7, 32'hFF7F_FFFF);
    chk_rd(5'd3, 32'h0001_2345, "rd_ch3");
    chk_rd(5'd7, 32'h007F_FFFF, "rd_ch7_zext");
    chk_attr(5'd3, 0, "attr_ch3_before");
    pulse_commit();
    chk_stat(1'b0, 1'b1, 1'b0, "wait_status");
    cyc(9);
    expect_busy("copy_len");
    expect_done(1'b0, "done_t2");
    pulse_frame();
    wait_idle("copy_t2");
    chk_attr(5'd3, 32'h0001_2345, "attr_ch3");
    chk_attr(5'd7, 32'h007F_FFFF, "attr_ch7");
    chk_attr(5'd0, 0, "attr_ch0");
    chk_attr(5'd4, 0, "attr_ch4");
    chk_attr(5'd31, 0, "attr_ch31");

    // 3: write during COPY is dropped
    pulse_commit();
    expect_busy("copy_len_t3");
    expect_done(1'b0, "done_t3");
    pulse_frame();
    cyc(3);
    wr(5'd5, 32'h0000_00AA);
    wait_idle("copy_t3");
    chk_rd(5'd5, 0, "rd_ch5_dropped");
    chk_stat(1'b0, 1'b0, 1'b1, "wr_drop_set");
    pulse_commit();
    chk_stat(1'b0, 1'b1, 1'b0, "wr_drop_cleared");

    // 4: commit during COPY chains into WAIT
    expect_busy("copy_len_t4a");
    expect_done(1'b1, "done_t4_pending");
    pulse_frame();
    cyc(5);
    pulse_commit();
    wait_idle("copy_t4a");
    chk_stat(1'b0, 1'b1, 1'b0, "t4_wait_status");
    wr(5'd9, 32'h0005_5555);
    chk_attr(5'd9, 0, "attr_ch9_before");
    expect_busy("copy_len_t4b");
    expect_done(1'b0, "done_t4b");
    pulse_frame();
    wait_idle("copy_t4b");
    chk_attr(5'd9, 32'h0005_5555, "attr_ch9");

    // 5: commit and frame_start together do not start a COPY
    wr(5'd2, 32'h0000_0003);
    commit_req = 1'b1; frame_start = 1'b1;
    tick();
    commit_req = 1'b0; frame_start = 1'b0;
    chk_stat(1'b0, 1'b1, 1'b0, "t5_wait");
    cyc(5);
    chk_stat(1'b0, 1'b1, 1'b0, "t5_still_wait");
    chk_attr(5'd2, 0, "attr_ch2_before");
    expect_busy("copy_len_t5");
    expect_done(1'b0, "done_t5");
    pulse_frame();
    wait_idle("copy_t5");
    chk_attr(5'd2, 32'h0000_0003, "attr_ch2");

    // 6: reset in the middle of COPY
    wr(5'd12, 32'h0000_0111);
    wr(5'd20, 32'h0000_0222);
    pulse_commit();
    expect_busy("reclear_len");
    pulse_frame();
    cyc(12);
    reset_n = 1'b0;
    chk_stat(1'b1, 1'b0, 1'b0, "t6_rst_status");
    chk_attr(5'd3, 0, "t6_rst_attr");
    reset_n = 1'b1;
    wait_idle("reclear");
    chk_stat(1'b0, 1'b0, 1'b0, "t6_post_status");
    chk_rd(5'd12, 0, "t6_rd_ch12");
    chk_rd(5'd20, 0, "t6_rd_ch20");
    chk_attr(5'd3, 0, "t6_attr_ch3");
    chk_attr(5'd7, 0, "t6_attr_ch7");
    chk_attr(5'd9, 0, "t6_attr_ch9");
    wr(5'd20, 32'h0000_0007);
    pulse_commit();
    expect_busy("copy_len_t6");
    expect_done(1'b0, "done_t6");
    pulse_frame();
    wait_idle("copy_t6");
    chk_attr(5'd20, 32'h0000_0007, "t6_attr_ch20");
    chk_attr(5'd12, 0, "t6_attr_ch12");

    cyc(3);
    cmp("leftover_expectations",
        q_rd.size() + q_stat.size() + q_attr.size() + q_done.size() + q_busy.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
